// File: rtl/sgbm_disp_select_if.sv
// sgbm_disp_select_if: cost stream, line-RAM read port and disparity result bus
// of the SGBM winner-take-all stage. Optional macro consumed by the design:
// SGBM_UNIQUENESS_EN.
`ifndef DISPD
`define DISPD 32
`endif
`ifndef COST_BITS
`define COST_BITS 12
`endif
`ifndef DISPD_BITS
`define DISPD_BITS 6
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif

interface sgbm_disp_select_if;
  logic [`DISPD*`COST_BITS-1:0] i_lr_cost;
  logic                         i_lr_valid;
  logic                         o_rd_req;
  logic [`DISPD*`COST_BITS-1:0] i_rl_cost;
  logic [`DISPD_BITS-1:0]       o_disp;
  logic                         o_disp_unique;
  logic                         o_disp_valid;

  modport master (
    output i_lr_cost, i_lr_valid, i_rl_cost,
    input  o_rd_req, o_disp, o_disp_unique, o_disp_valid
  );
  modport slave (
    input  i_lr_cost, i_lr_valid, i_rl_cost,
    output o_rd_req, o_disp, o_disp_unique, o_disp_valid
  );
endinterface

// File: rtl/sgbm_disp_select.sv
// sgbm_disp_select: sums left-to-right and right-to-left aggregated costs per
// disparity lane and picks the minimum-cost disparity per pixel.
// Optional feature macro: SGBM_UNIQUENESS_EN (second-minimum uniqueness test,
// adds one pipeline stage).
//
// state | meaning
// IDLE  | no line armed, waiting for i_line_start
// RUN   | accepting cost beats until N pixels are read
// DRAIN | all beats accepted, waiting for the pipeline to empty
`ifndef DISPD
`define DISPD 32
`endif
`ifndef COST_BITS
`define COST_BITS 12
`endif
`ifndef DISPD_BITS
`define DISPD_BITS 6
`endif
`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif

module sgbm_disp_select (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_line_start,
  input  logic [`WIDTH_BITS-1:0] i_width,
  input  logic [`DISPD_BITS-1:0] i_min_disp,
  input  logic [`DISPD_BITS-1:0] i_max_disp,
  input  logic [6:0]             i_uniq_ratio,
  sgbm_disp_select_if.slave      bus,
  output logic                   o_line_done,
  output logic                   o_busy
);
  localparam int D  = `DISPD;
  localparam int CB = `COST_BITS;
  localparam int SB = `COST_BITS + 1;
  localparam int DB = `DISPD_BITS;
  localparam int WB = `WIDTH_BITS;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state;
  logic [WB-1:0]          rem_cnt;
  logic [WB-1:0]          n_pix;
  logic [DB-1:0]          min_disp_q;
  logic [DB-1:0]          max_disp_q;
  logic                   accept;
  logic                   abort;
  logic                   pipe_empty;
  int                     lane_span;

  logic [D*CB-1:0]        lr_q;
  logic [D-1:0][SB-1:0]   s_comb;
  logic [D-1:0][SB-1:0]   s_q;
  logic [SB-1:0]          min_val;
  logic [DB-1:0]          min_idx;
  logic [DB-1:0]          arg_q;
  logic                   v1, v2, v3;
  logic [DB-1:0]          fin_arg;
  logic                   fin_uniq;
  logic                   fin_v;

  // pixels per line; columns below max_disp have no full disparity range
  assign n_pix     = (i_width > WB'(i_max_disp)) ? i_width - WB'(i_max_disp) : '0;
  assign accept    = (state == RUN) && bus.i_lr_valid && (rem_cnt != '0) && !i_line_start;
  assign abort     = i_line_start && (state != IDLE);
  assign bus.o_rd_req = accept;
  assign o_busy    = (state != IDLE);
  assign lane_span = int'(max_disp_q) - int'(min_disp_q);

  // line sequencer: remaining-pixel down-counter, drain and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rem_cnt     <= '0;
      min_disp_q  <= '0;
      max_disp_q  <= '0;
      o_line_done <= 1'b0;
    end else begin
      o_line_done <= 1'b0;
      if (i_line_start) begin
        state      <= RUN;
        rem_cnt    <= n_pix;
        min_disp_q <= i_min_disp;
        max_disp_q <= i_max_disp;
      end else begin
        case (state)
          RUN: begin
            if (accept) rem_cnt <= rem_cnt - WB'(1);
            if ((rem_cnt == '0) || (accept && (rem_cnt == WB'(1)))) state <= DRAIN;
          end
          DRAIN: begin
            if (pipe_empty) begin
              o_line_done <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // per-lane cost sum; lanes outside the configured range never win
  always_comb begin
    s_comb = '1;
    for (int d = 0; d < D; d++) begin
      if (d < lane_span)
        s_comb[d] = {1'b0, lr_q[(D-1-d)*CB +: CB]} + {1'b0, bus.i_rl_cost[(D-1-d)*CB +: CB]};
    end
  end

  // minimum search; strict compare keeps the lowest lane on ties
  always_comb begin
    min_val = s_q[0];
    min_idx = '0;
    for (int d = 1; d < D; d++) begin
      if (s_q[d] < min_val) begin
        min_val = s_q[d];
        min_idx = DB'(d);
      end
    end
  end

`ifdef SGBM_UNIQUENESS_EN
  localparam int PB = SB + 7;
  logic [6:0]           ratio_q;
  logic [D-1:0][SB-1:0] s3_q;
  logic [SB-1:0]        min_q;
  logic [SB-1:0]        s2;
  logic [PB-1:0]        lhs, rhs;
  logic [DB-1:0]        arg_u_q;
  logic                 uniq_u_q;
  logic                 vu;

  // config ratio follows the line it was armed with
  always_ff @(posedge clk) begin
    if (rst) ratio_q <= '0;
    else if (i_line_start) ratio_q <= i_uniq_ratio;
  end

  // second minimum over lanes not adjacent to the winner
  always_comb begin
    s2 = '1;
    for (int d = 0; d < D; d++) begin
      if (((d > int'(arg_q) + 1) || (d < int'(arg_q) - 1)) && (s3_q[d] < s2))
        s2 = s3_q[d];
    end
    lhs = PB'(s2) * PB'(7'd100 - ratio_q);
    rhs = PB'(min_q) * PB'(100);
  end

  // uniqueness stage registers
  always_ff @(posedge clk) begin
    arg_u_q  <= arg_q;
    uniq_u_q <= !(lhs < rhs);
  end

  // uniqueness stage valid, flushed on reset or abort
  always_ff @(posedge clk) begin
    if (rst || abort) vu <= 1'b0;
    else              vu <= v3;
  end

  // stage-3 copy of the sums for the second-minimum search
  always_ff @(posedge clk) begin
    s3_q  <= s_q;
    min_q <= min_val;
  end

  assign fin_arg    = arg_u_q;
  assign fin_uniq   = uniq_u_q & vu;
  assign fin_v      = vu;
  assign pipe_empty = !v1 && !v2 && !v3 && !vu;
`else
  logic unused_ratio;
  assign unused_ratio = ^i_uniq_ratio;
  assign fin_arg      = arg_q;
  assign fin_uniq     = v3;
  assign fin_v        = v3;
  assign pipe_empty   = !v1 && !v2 && !v3;
`endif

  // datapath registers: align lr with RAM data, sums, argmin
  always_ff @(posedge clk) begin
    lr_q  <= bus.i_lr_cost;
    s_q   <= s_comb;
    arg_q <= min_idx;
  end

  // valid pipeline and output registers; abort flushes in-flight beats
  always_ff @(posedge clk) begin
    if (rst) begin
      v1                <= 1'b0;
      v2                <= 1'b0;
      v3                <= 1'b0;
      bus.o_disp        <= '0;
      bus.o_disp_unique <= 1'b0;
      bus.o_disp_valid  <= 1'b0;
    end else if (abort) begin
      v1                <= 1'b0;
      v2                <= 1'b0;
      v3                <= 1'b0;
      bus.o_disp_unique <= 1'b0;
      bus.o_disp_valid  <= 1'b0;
    end else begin
      v1                <= accept;
      v2                <= v1;
      v3                <= v2;
      bus.o_disp_valid  <= fin_v;
      bus.o_disp_unique <= fin_uniq;
      if (fin_v) bus.o_disp <= min_disp_q + fin_arg;
    end
  end
endmodule

// File: doc/sgbm_disp_select.md
# sgbm_disp_select

Line-level reader and winner-take-all stage for the SGBM aggregation path. Consumes the left-to-right aggregated cost stream, issues read requests to the right-to-left aggregator's line RAM, sums both directional costs per disparity and selects the minimum-cost disparity per pixel. Sits between the two directional aggregators and the disparity output writer; one instance per image line pipeline.

## Interface
Parameters (all from `sgbm_defines.v`, no module parameters):
- `DISPD`, defined, number of disparity lanes.
- `COST_BITS`, defined, width of one aggregated cost.
- `DISPD_BITS`, defined, disparity index width.
- `WIDTH_BITS`, defined, column counter width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- i_line_start  in  1  one-cycle pulse, arms a new line.
- i_width  in  WIDTH_BITS  image width; sampled on i_line_start.
- i_min_disp  in  DISPD_BITS  minimum disparity; sampled on i_line_start.
- i_max_disp  in  DISPD_BITS  maximum disparity; sampled on i_line_start.
- i_uniq_ratio  in  7  uniqueness ratio in percent, 0..99; sampled on i_line_start.
- i_lr_cost  in  DISPD*COST_BITS  left-to-right aggregated costs, lane 0 in MSBs.
- i_lr_valid  in  1  i_lr_cost valid this cycle.
- o_rd_req  out  1  advance right-to-left RAM read pointer.
- i_rl_cost  in  DISPD*COST_BITS  right-to-left RAM data, valid exactly one cycle after o_rd_req.
- o_disp  out  DISPD_BITS  selected disparity = min_disp + argmin lane.
- o_disp_unique  out  1  1 = passes uniqueness test.
- o_disp_valid  out  1  o_disp/o_disp_unique valid.
- o_line_done  out  1  one-cycle pulse after last pixel of the line is output.
- o_busy  out  1  high in RUN or DRAIN.

## Operation
- States: IDLE, RUN, DRAIN. Reset -> IDLE.
- IDLE -> RUN on i_line_start; latch config; pixel count N = i_width - i_max_disp; accepted counter cleared.
- RUN: o_rd_req = i_lr_valid while accepted < N (combinational). Each accepted beat increments counter. i_lr_valid beyond N ignored, no o_rd_req.
- RUN -> DRAIN on the cycle the N-th beat is accepted. DRAIN waits until pipeline empty, pulses o_line_done, -> IDLE.
- i_line_start in RUN/DRAIN: abort; pipeline valids cleared same cycle, no o_line_done for aborted line, new line armed (-> RUN).
- Stage 1: i_lr_cost delayed one cycle to align with i_rl_cost.
- Stage 2: per lane S[d] = lr[d] + rl[d], COST_BITS+1 bits, no saturation; lanes d >= max_disp - min_disp forced to all-ones.
- Stage 3: min tree over S, registered min value and argmin; ties -> lowest lane.
- Output stage: register o_disp, o_disp_unique, o_disp_valid.
- N = 0 (i_width <= i_max_disp): RUN -> DRAIN immediately, o_line_done pulses with no pixel output.

## Timing
- Reset values: o_disp=0, o_disp_unique=0, o_disp_valid=0, o_line_done=0, o_busy=0, o_rd_req=0.
- Latency i_lr_valid -> o_disp_valid: 4 cycles (5 with SGBM_UNIQUENESS_EN). Throughput 1 pixel/cycle, gaps in i_lr_valid preserved at output.
- o_line_done asserts the cycle after the last o_disp_valid of the line.
- o_rd_req is the only backward signal; no stall capability, upstream never throttled.

## Configuration
- `SGBM_UNIQUENESS_EN` defined: extra stage computes second minimum S2 over lanes with |d - best| > 1; o_disp_unique = !(S2*(100 - ratio) < Smin*100); latency 5.
- Undefined: no second-min logic, o_disp_unique = o_disp_valid, i_uniq_ratio ignored, latency 4.

## Test plan
- Width 16, min 0, max 4, single lane cost dip (lr[2]=10, rl[2]=5, others 100) for all 12 beats -> 12 o_disp_valid, o_disp=2, o_line_done one cycle after 12th.
- Tie lanes 1 and 3 at sum 20 -> o_disp=1; min_disp=8 same costs -> o_disp=9.
- Gapped i_lr_valid (1 on, 2 off) -> o_rd_req mirrors accepted beats, output spacing identical, 14th beat after N=12 produces no o_rd_req/output.
- i_line_start pulsed mid-RUN after 5 beats -> no o_line_done for aborted line, new line yields full N outputs.
- Uniqueness EN, ratio 15, Smin=100 at lane 5, S[20]=110 -> o_disp_unique=0; S[20]=120 -> 1; S[6]=101 (neighbour) ignored -> 1.
- rst asserted in DRAIN -> next cycle all outputs 0, state IDLE, no o_line_done.
